// File: rtl/lcd_cmd_scheduler.sv
// Character-LCD bus owner: power-on wait, init ROM playback, then
// round-robin arbitration of two byte requesters with EN/exec timing.
module lcd_cmd_scheduler #(
    parameter int T_POWERON = 2_000_000,
    parameter int T_SETUP   = 2,
    parameter int T_EN_HIGH = 25,
    parameter int T_CMD     = 2_000,
    parameter int T_CLEAR   = 82_000,
    parameter int T_LONG    = 205_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DADOS,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_POWERON, S_I_SETUP, S_I_PULSE, S_I_WAIT,
        S_IDLE, S_SETUP, S_PULSE, S_WAIT
    } state_t;

    localparam logic [20:0] C_PWR  = 21'(T_POWERON - 1);
    localparam logic [20:0] C_SET  = 21'(T_SETUP - 1);
    localparam logic [20:0] C_EN   = 21'(T_EN_HIGH - 1);
    localparam logic [20:0] C_CMD  = 21'(T_CMD - 1);
    localparam logic [20:0] C_CLR  = 21'(T_CLEAR - 1);
    localparam logic [20:0] C_LONG = 21'(T_LONG - 1);

    state_t      r_state;
    state_t      w_next;
    logic [20:0] r_cnt;
    logic [20:0] w_load;
    logic [2:0]  r_idx;
    logic        r_rr_last;
    logic        r_init_done;
    logic        r_rs;
    logic [7:0]  r_data;
    logic        w_done;
    logic        w_any;
    logic        w_grant1;
    logic        w_clear;
    logic [7:0]  w_rom;

    function automatic logic [7:0] f_rom(input logic [2:0] i);
        logic [7:0] b;
        unique case (i)
            3'd0, 3'd1, 3'd2: b = 8'h30;
            3'd3:             b = 8'h38;
            3'd4:             b = 8'h0C;
            3'd5:             b = 8'h01;
            3'd6:             b = 8'h06;
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_done   = (r_cnt == 21'd0);
    assign w_any    = req0_valid | req1_valid;
    assign w_grant1 = req1_valid & (~req0_valid | ~r_rr_last);
    assign w_rom    = f_rom(r_idx);
    assign w_clear  = ~r_rs & (r_data == 8'h01 | r_data == 8'h02 |
                               r_data == 8'h03);

    // state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= S_POWERON;
        else       r_state <= w_next;
    end

    // next-state: timed states leave when the counter reads 0
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_POWERON: if (w_done) w_next = S_I_SETUP;
            S_I_SETUP: if (w_done) w_next = S_I_PULSE;
            S_I_PULSE: if (w_done) w_next = S_I_WAIT;
            S_I_WAIT:
                if (w_done)
                    w_next = (r_idx == 3'd6) ? S_IDLE : S_I_SETUP;
            S_IDLE:    if (w_any) w_next = S_SETUP;
            S_SETUP:   if (w_done) w_next = S_PULSE;
            S_PULSE:   if (w_done) w_next = S_WAIT;
            S_WAIT:    if (w_done) w_next = S_IDLE;
        endcase
    end

    // outputs decoded from state; handshake is combinational in IDLE
    always_comb begin
        LCD_EN     = (r_state == S_I_PULSE) | (r_state == S_PULSE);
        LCD_RW     = 1'b0;
        busy       = (r_state != S_IDLE);
        req0_ready = (r_state == S_IDLE) & req0_valid & ~w_grant1;
        req1_ready = (r_state == S_IDLE) & w_grant1;
    end

    // duration-1 to load on entry to the next state
    always_comb begin
        w_load = '0;
        unique case (w_next)
            S_POWERON:          w_load = C_PWR;
            S_I_SETUP, S_SETUP: w_load = C_SET;
            S_I_PULSE, S_PULSE: w_load = C_EN;
            S_I_WAIT:
                if (r_idx == 3'd0)       w_load = C_LONG;
                else if (w_rom == 8'h01) w_load = C_CLR;
                else                     w_load = C_CMD;
            S_WAIT:  w_load = w_clear ? C_CLR : C_CMD;
            S_IDLE:  w_load = '0;
        endcase
    end

    // shared down-counter, reloaded on every state change
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                  r_cnt <= C_PWR;
        else if (w_next != r_state) r_cnt <= w_load;
        else if (!w_done)           r_cnt <= r_cnt - 21'd1;
    end

    // bus byte, init index, arbitration history
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_idx       <= 3'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_rr_last   <= 1'b1;
        end else begin
            if (r_state == S_I_WAIT && w_done) begin
                if (r_idx == 3'd6) r_init_done <= 1'b1;
                else               r_idx <= r_idx + 3'd1;
            end
            if (w_next == S_I_SETUP && r_state != S_I_SETUP) begin
                r_rs   <= 1'b0;
                r_data <= f_rom((r_state == S_I_WAIT) ?
                                r_idx + 3'd1 : r_idx);
            end
            if (r_state == S_IDLE && w_any) begin
                r_rs      <= w_grant1 ? req1_rs : req0_rs;
                r_data    <= w_grant1 ? req1_data : req0_data;
                r_rr_last <= w_grant1;
            end
        end
    end

    assign LCD_RS    = r_rs;
    assign LCD_DADOS = r_data;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Bench for lcd_cmd_scheduler: timeline model checked every cycle,
// directed init/handshake/reset scenarios, then random traffic.
module tb_lcd_cmd_scheduler;

    localparam int TP  = 50;
    localparam int TS  = 2;
    localparam int TE  = 5;
    localparam int TC  = 20;
    localparam int TCL = 60;
    localparam int TL  = 90;

    logic       Clock;
    logic       Reset;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       LCD_EN, LCD_RS, LCD_RW;
    logic [7:0] LCD_DADOS;
    logic       init_done, busy;

    lcd_cmd_scheduler #(
        .T_POWERON(TP), .T_SETUP(TS), .T_EN_HIGH(TE),
        .T_CMD(TC), .T_CLEAR(TCL), .T_LONG(TL)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .req0_valid(req0_valid), .req0_rs(req0_rs),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_DADOS(LCD_DADOS), .init_done(init_done), .busy(busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    localparam logic [7:0] ROM [7] = '{8'h30, 8'h30, 8'h30, 8'h38,
                                       8'h0C, 8'h01, 8'h06};

    // timeline model: one byte job at a time, start cycle + wait length
    int         n;
    bit         m_pwr, m_idle, m_done, m_init, m_rr;
    int         m_k, m_s, m_w;
    logic       m_rs;
    logic [7:0] m_d;
    logic       prev_en;
    int         rise_n[$];
    int         rise_d[$];

    always @(negedge Clock) begin
        logic e_en, e_r0, e_r1;
        if (Reset) begin
            n = 0; m_pwr = 1; m_idle = 0; m_done = 0; m_init = 1;
            m_k = 0; m_s = 0; m_w = 0; m_rs = 0; m_d = 0; m_rr = 1;
            prev_en = 0;
            rise_n.delete();
            rise_d.delete();
            chk("rst_en", int'(LCD_EN), 0);
            chk("rst_rs", int'(LCD_RS), 0);
            chk("rst_dados", int'(LCD_DADOS), 0);
            chk("rst_done", int'(init_done), 0);
            chk("rst_busy", int'(busy), 1);
            chk("rst_rdy", int'({req0_ready, req1_ready}), 0);
        end else begin
            n++;
            if (m_pwr) begin
                if (n == TP) begin
                    m_pwr = 0; m_k = 0; m_init = 1; m_s = n;
                    m_rs = 0; m_d = ROM[0]; m_w = TL;
                end
            end else if (!m_idle && n == m_s + TS + TE + m_w) begin
                if (m_init && m_k < 6) begin
                    m_k++; m_s = n; m_rs = 0; m_d = ROM[m_k];
                    m_w = (m_d == 8'h01) ? TCL : TC;
                end else begin
                    m_idle = 1;
                    if (m_init) m_done = 1;
                end
            end
            e_en = !m_pwr && !m_idle && n >= m_s + TS &&
                   n < m_s + TS + TE;
            e_r0 = m_idle && req0_valid && (!req1_valid || m_rr);
            e_r1 = m_idle && req1_valid && (!req0_valid || !m_rr);
            chk("en", int'(LCD_EN), int'(e_en));
            chk("rs", int'(LCD_RS), int'(m_rs));
            chk("dados", int'(LCD_DADOS), int'(m_d));
            chk("rw", int'(LCD_RW), 0);
            chk("busy", int'(busy), int'(!m_idle));
            chk("init_done", int'(init_done), int'(m_done));
            chk("ready0", int'(req0_ready), int'(e_r0));
            chk("ready1", int'(req1_ready), int'(e_r1));
            if (LCD_EN && !prev_en) begin
                rise_n.push_back(n);
                rise_d.push_back(int'(LCD_DADOS));
            end
            prev_en = LCD_EN;
            if (e_r0 || e_r1) begin
                m_rr = e_r1;
                m_rs = e_r1 ? req1_rs : req0_rs;
                m_d  = e_r1 ? req1_data : req0_data;
                m_w  = (!m_rs && m_d >= 8'd1 && m_d <= 8'd3) ? TCL : TC;
                m_s = n + 1; m_idle = 0; m_init = 0;
            end
        end
    end

    task automatic smp();
        @(negedge Clock); #1;
    endtask

    task automatic tck();
        @(posedge Clock); #1;
    endtask

    task automatic drive(input int who, input logic v, input logic rs,
                         input logic [7:0] d);
        if (who == 0) begin
            req0_valid = v; req0_rs = rs; req0_data = d;
        end else begin
            req1_valid = v; req1_rs = rs; req1_data = d;
        end
    endtask

    task automatic send(input int who, input logic rs,
                        input logic [7:0] d, output int at);
        bit got = 0;
        drive(who, 1'b1, rs, d);
        at = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            smp();
            if (who == 0 ? (req0_valid && req0_ready)
                         : (req1_valid && req1_ready)) begin
                at = n; got = 1;
            end
            tck();
        end
        if (!got) chk("send_timeout", 0, 1);
        drive(who, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle_wait(output int at);
        bit got = 0;
        at = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            smp();
            if (!busy) begin at = n; got = 1; end
            tck();
        end
        if (!got) chk("idle_timeout", 0, 1);
    endtask

    task automatic release_reset();
        @(negedge Clock); #1;
        Reset = 1'b0;
        tck();
    endtask

    task automatic check_init();
        int exp_n [8] = '{52, 149, 176, 203, 230, 257, 324, 352};
        int exp_d [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01,
                          8'h06, 8'h41};
        chk("rise_count_ge8", int'(rise_n.size() >= 8), 1);
        for (int i = 0; i < 8 && i < rise_n.size(); i++) begin
            chk($sformatf("rise_cyc%0d", i), rise_n[i], exp_n[i]);
            chk($sformatf("rise_byte%0d", i), rise_d[i], exp_d[i]);
        end
    endtask

    initial begin
        int a, t, first_done;
        int grants[$];
        int exp_g [4] = '{0, 1, 0, 1};
        bit a0, a1;
        Reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        repeat (3) tck();
        release_reset();

        // request pending from cycle 10 through power-on and init
        repeat (9) begin smp(); tck(); end
        send(0, 1'b1, 8'h41, a);
        chk("pending_accept_cyc", a, 349);
        idle_wait(t);
        chk("data_busy_len", t - a, 28);
        check_init();

        // clear command vs same byte as data
        send(1, 1'b0, 8'h01, a);
        idle_wait(t);
        chk("clear_busy_len", t - a, 68);
        send(1, 1'b1, 8'h01, a);
        idle_wait(t);
        chk("data01_busy_len", t - a, 28);

        // reset while EN is high
        send(0, 1'b1, 8'h55, a);
        t = 0;
        for (int i = 0; i < 100 && !t; i++) begin
            smp();
            if (LCD_EN) t = 1;
            else tck();
        end
        chk("saw_pulse", t, 1);
        tck();
        chk("en_before_rst", int'(LCD_EN), 1);
        Reset = 1'b1;
        #1;
        chk("rst_async_en", int'(LCD_EN), 0);
        chk("rst_async_dados", int'(LCD_DADOS), 0);
        chk("rst_async_done", int'(init_done), 0);
        chk("rst_async_busy", int'(busy), 1);
        repeat (2) tck();
        release_reset();

        // both requesters continuously valid after a fresh init
        drive(0, 1'b1, 1'b1, 8'h41);
        drive(1, 1'b1, 1'b1, 8'h42);
        first_done = -1;
        for (int i = 0; i < 3000 && grants.size() < 4; i++) begin
            smp();
            if (init_done && first_done < 0) first_done = n;
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            tck();
        end
        chk("init_done_cyc", first_done, 349);
        chk("grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("grant%0d", i), grants[i], exp_g[i]);
        check_init();

        // random traffic, including withdrawn requests
        for (int c = 0; c < 6000; c++) begin
            smp();
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            tck();
            for (int w = 0; w < 2; w++) begin
                bit acc = (w == 0) ? a0 : a1;
                bit v = (w == 0) ? req0_valid : req1_valid;
                if (acc || (!v && $urandom_range(0, 3) == 0)) begin
                    if ($urandom_range(0, 7) == 0)
                        drive(w, 1'($urandom_range(0, 2) != 0), 1'b0,
                              8'($urandom_range(1, 3)));
                    else
                        drive(w, 1'($urandom_range(0, 2) != 0),
                              1'($urandom_range(0, 1)),
                              8'($urandom_range(0, 255)));
                end else if (v && $urandom_range(0, 31) == 0) begin
                    drive(w, 1'b0, 1'b0, 8'h00);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        repeat (2) tck();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
